// File: rtl/debounced_logic_gate.sv
// Switch-to-LED logic unit: per-bit 2-flop synchroniser and debouncer feeding a
// registered AND/OR/XOR/NAND reduction. Optional L rising-edge counter: EDGE_CNT_EN.
module debounced_logic_gate #(
  parameter int N         = 2,
  parameter int DB_CYCLES = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] SW,
  input  logic [1:0]   MODE,
  output logic         L,
  output logic         CHG,
  output logic [7:0]   CNT
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [N-1:0]  s1_q, s2_q;
  logic [N-1:0]  db_q, db_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic          l_q, l_d;
  logic          chg_q;

  // Any sample matching the held level discards the partial count.
  always_comb begin
    db_d = db_q;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    l_d = 1'b0;
    case (MODE)
      2'b00:   l_d = &db_q;
      2'b01:   l_d = |db_q;
      2'b10:   l_d = ^db_q;
      default: l_d = ~&db_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q  <= '0;
      s2_q  <= '0;
      db_q  <= '0;
      l_q   <= 1'b0;
      chg_q <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q  <= SW;
      s2_q  <= s1_q;
      db_q  <= db_d;
      l_q   <= l_d;
      chg_q <= (l_d != l_q);
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign L   = l_q;
  assign CHG = chg_q;

`ifdef EDGE_CNT_EN
  logic [7:0] edge_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt_q <= '0;
    end else if (l_d && !l_q) begin
      edge_cnt_q <= edge_cnt_q + 8'd1;
    end
  end

  assign CNT = edge_cnt_q;
`else
  assign CNT = '0;
`endif

endmodule

// File: tb/tb_debounced_logic_gate.sv
// Directed self-checking bench for debounced_logic_gate (N=2, DB_CYCLES=4).
module tb_debounced_logic_gate;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] SW;
  logic [1:0] MODE;
  logic       L;
  logic       CHG;
  logic [7:0] CNT;

  int checks   = 0;
  int failures = 0;

`ifdef EDGE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  debounced_logic_gate #(.N(2), .DB_CYCLES(4)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .SW   (SW),
    .MODE (MODE),
    .L    (L),
    .CHG  (CHG),
    .CNT  (CNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_cnt;

    // Reset and idle
    RST = 1'b1; SW = 2'b00; MODE = 2'b00;
    tick(); tick();
    chk("rst_L", {7'd0, L}, 8'd0);
    chk("rst_CHG", {7'd0, CHG}, 8'd0);
    chk("rst_CNT", CNT, 8'd0);
    RST = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("idle_L", {7'd0, L}, 8'd0);
      chk("idle_CHG", {7'd0, CHG}, 8'd0);
      chk("idle_CNT", CNT, 8'd0);
    end

    // AND latency: L rises exactly at edge 7
    SW = 2'b11;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("and_rise_early_L", {7'd0, L}, 8'd0);
      chk("and_rise_early_CHG", {7'd0, CHG}, 8'd0);
    end
    tick();
    chk("and_rise_L", {7'd0, L}, 8'd1);
    chk("and_rise_CHG", {7'd0, CHG}, 8'd1);
    chk("and_rise_CNT", CNT, CNT_EN ? 8'd1 : 8'd0);
    tick();
    chk("and_rise_hold_L", {7'd0, L}, 8'd1);
    chk("and_rise_chg_once", {7'd0, CHG}, 8'd0);
    tick(); tick(); tick();

    SW = 2'b01;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("and_fall_early_L", {7'd0, L}, 8'd1);
    end
    tick();
    chk("and_fall_L", {7'd0, L}, 8'd0);
    chk("and_fall_CHG", {7'd0, CHG}, 8'd1);
    tick();
    chk("and_fall_chg_once", {7'd0, CHG}, 8'd0);

    // Glitch rejection: 3-cycle low pulse ignored, 4-cycle pulse accepted
    SW = 2'b11;
    repeat (7) tick();
    chk("reraise_L", {7'd0, L}, 8'd1);
    tick(); tick(); tick();
    SW = 2'b01;
    repeat (3) tick();
    SW = 2'b11;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("pulse3_L", {7'd0, L}, 8'd1);
      chk("pulse3_CHG", {7'd0, CHG}, 8'd0);
    end
    SW = 2'b01;
    repeat (4) tick();
    SW = 2'b11;
    tick(); tick();
    chk("pulse4_pre_L", {7'd0, L}, 8'd1);
    tick();
    chk("pulse4_L", {7'd0, L}, 8'd0);
    chk("pulse4_CHG", {7'd0, CHG}, 8'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("pulse4_low_L", {7'd0, L}, 8'd0);
    end
    tick();
    chk("pulse4_back_L", {7'd0, L}, 8'd1);
    chk("pulse4_back_CHG", {7'd0, CHG}, 8'd1);
    tick(); tick(); tick();

    // Mode switching with DB=11, MODE takes effect on the next edge
    MODE = 2'b10;
    tick();
    chk("xor11_L", {7'd0, L}, 8'd0);
    chk("xor11_CHG", {7'd0, CHG}, 8'd1);
    tick();
    chk("xor11_chg_once", {7'd0, CHG}, 8'd0);
    MODE = 2'b11;
    tick();
    chk("nand11_L", {7'd0, L}, 8'd0);
    chk("nand11_CHG", {7'd0, CHG}, 8'd0);
    MODE = 2'b01;
    tick();
    chk("or11_L", {7'd0, L}, 8'd1);
    chk("or11_CHG", {7'd0, CHG}, 8'd1);

    // XOR / NAND / AND with mixed switches
    MODE = 2'b10;
    tick();
    chk("xor11b_L", {7'd0, L}, 8'd0);
    SW = 2'b01;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("xor01_early_L", {7'd0, L}, 8'd0);
    end
    tick();
    chk("xor01_L", {7'd0, L}, 8'd1);
    chk("xor01_CHG", {7'd0, CHG}, 8'd1);
    MODE = 2'b11;
    tick();
    chk("nand01_L", {7'd0, L}, 8'd1);
    chk("nand01_CHG", {7'd0, CHG}, 8'd0);
    MODE = 2'b00;
    tick();
    chk("and01_L", {7'd0, L}, 8'd0);
    chk("and01_CHG", {7'd0, CHG}, 8'd1);

    // Reset mid-debounce discards progress
    RST = 1'b1; SW = 2'b00; MODE = 2'b00;
    tick();
    RST = 1'b0;
    repeat (4) tick();
    SW = 2'b11;
    repeat (3) tick();
    RST = 1'b1;
    tick();
    chk("midrst_L", {7'd0, L}, 8'd0);
    chk("midrst_CNT", CNT, 8'd0);
    RST = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("midrst_early_L", {7'd0, L}, 8'd0);
    end
    tick();
    chk("midrst_L_rise", {7'd0, L}, 8'd1);
    chk("midrst_CHG", {7'd0, CHG}, 8'd1);

    // NAND after reset: L rises on the first edge
    RST = 1'b1; SW = 2'b00; MODE = 2'b11;
    tick();
    chk("nandrst_L", {7'd0, L}, 8'd0);
    chk("nandrst_CHG", {7'd0, CHG}, 8'd0);
    RST = 1'b0;
    tick();
    chk("nandrel_L", {7'd0, L}, 8'd1);
    chk("nandrel_CHG", {7'd0, CHG}, 8'd1);
    tick();
    chk("nandrel_L2", {7'd0, L}, 8'd1);
    chk("nandrel_chg_once", {7'd0, CHG}, 8'd0);

    // Edge counter: 256 rising edges of L wrap the 8-bit count
    RST = 1'b1; SW = 2'b00; MODE = 2'b01;
    tick();
    RST = 1'b0;
    repeat (4) tick();
    exp_cnt = 8'd0;
    for (int k = 0; k < 256; k++) begin
      SW = 2'b01;
      repeat (8) tick();
      chk("cnt_L_high", {7'd0, L}, 8'd1);
      SW = 2'b00;
      repeat (8) tick();
      if (CNT_EN) exp_cnt = exp_cnt + 8'd1;
      chk("cnt_value", CNT, exp_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
